// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell per cycle, LSB first.
// Subtraction is a + ~b + 1, with the +1 injected through the carry flop.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic sum_bit, cy_next, last_bit, load;

  assign sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign cy_next  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  // a new operation may be accepted from IDLE or directly out of DONE
  assign load     = start && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (load) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
      carry_d = cy_next;
      cnt_d   = cnt_q + CW'(1);
      if (last_bit) begin
        result_d = acc_d;
        cout_d   = cy_next;
        // carry_q is the carry into the MSB cell on this final step
        ovf_d    = carry_q ^ cy_next;
        zero_d   = (acc_d == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: driver pushes reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_addsub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, overflow, zero;
  logic [W-1:0] result;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t         q[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] last_res = '0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    exp_t   e;
    longint ua = ia;
    longint ub = ib;
    longint sa = $signed(ia);
    longint sb = $signed(ib);
    longint u, s;
    u      = isub ? ua - ub : ua + ub;
    s      = isub ? sa - sb : sa + sb;
    e.res  = u[W-1:0];
    e.cout = isub ? (ua >= ub) : (u >= (longint'(1) << W));
    e.ovf  = (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
    e.zero = (e.res == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("cout", 32'(cout), 32'(e.cout));
          chk("overflow", 32'(overflow), 32'(e.ovf));
          chk("zero", 32'(zero), 32'(e.zero));
          last_res = e.res;
        end
      end else if (busy) begin
        chk("hold_during_shift", 32'(result), 32'(last_res));
      end
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub, input bit push);
    start = 1'b1;
    a     = ia;
    b     = ib;
    sub   = isub;
    if (push) q.push_back(model(ia, ib, isub));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns in the done cycle; scribbles on inputs while busy to prove they are ignored
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin
      if (busy) begin
        start = 1'($urandom_range(1));
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom_range(1));
        if (n == 3) begin
          start = 1'b1;
          a     = '1;
          b     = '1;
        end
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
  } vec_t;

  vec_t dir[7] = '{
    '{8'h3C, 8'h05, 1'b0},
    '{8'h7F, 8'h01, 1'b0},
    '{8'hFF, 8'h01, 1'b0},
    '{8'h05, 8'h07, 1'b1},
    '{8'h80, 8'h01, 1'b1},
    '{8'h33, 8'h00, 1'b1},
    '{8'h00, 8'h00, 1'b0}
  };

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", 32'({cout, overflow, zero}), 32'd0);
    rst      = 1'b0;
    last_res = '0;
    @(posedge clk); #1;

    foreach (dir[i]) begin
      issue(dir[i].a, dir[i].b, dir[i].sub, 1'b1);
      wait_done(n);
      chk("latency", 32'(n), 32'(W + 1));
      @(posedge clk); #1;
    end

    // start held in the DONE cycle chains straight into the next op
    issue(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done(n);
    chk("latency_b2b_first", 32'(n), 32'(W + 1));
    issue(8'h44, 8'h11, 1'b1, 1'b1);
    wait_done(n);
    chk("latency_b2b_second", 32'(n), 32'(W + 1));
    @(posedge clk); #1;

    // abort mid-shift: rst sampled at the end of cycle 4
    issue(8'h55, 8'h22, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", 32'({cout, overflow, zero}), 32'd0);
    rst      = 1'b0;
    last_res = '0;
    repeat (W + 3) begin @(posedge clk); #1; end
    issue(8'h01, 8'h01, 1'b0, 1'b1);
    wait_done(n);
    chk("latency_after_abort", 32'(n), 32'(W + 1));
    @(posedge clk); #1;

    // start asserted while rst is high is taken on the first non-reset edge
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hC8;
    b     = 8'h64;
    sub   = 1'b0;
    @(posedge clk); #1;
    chk("reset_with_start_busy", 32'(busy), 32'd0);
    rst      = 1'b0;
    last_res = '0;
    q.push_back(model(8'hC8, 8'h64, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("latency_reset_release", 32'(n), 32'(W + 1));
    @(posedge clk); #1;

    repeat (40) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(1)), 1'b1);
      wait_done(n);
      chk("latency_rand", 32'(n), 32'(W + 1));
      if ($urandom_range(1) == 1) begin @(posedge clk); #1; end
    end

    @(posedge clk); #1;
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001: Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004: start  input  1  request new operation; sampled only when busy=0.
REQ-005: sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006: a  input  WIDTH  operand A; sampled with start.
REQ-007: b  input  WIDTH  operand B; sampled with start.
REQ-008: busy  output  1  high while operation in progress.
REQ-009: done  output  1  one-cycle pulse when result/flags valid.
REQ-010: result  output  WIDTH  registered sum/difference.
REQ-011: cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-012: overflow  output  1  two's-complement signed overflow.
REQ-013: zero  output  1  1 when result == 0.

Function
REQ-014: Datapath SHALL be bit-serial: exactly one full-adder bit cell (a^b^c sum, majority carry) evaluated per cycle, LSB first, carry held in a flip-flop between cycles.
REQ-015: FSM SHALL have states IDLE, SHIFT, DONE.
REQ-016: IDLE with start=1: load A shift reg = a, B shift reg = (sub ? ~b : b), carry FF = sub, bit counter = 0; next state SHIFT.
REQ-017: IDLE with start=0: remain IDLE, outputs hold.
REQ-018: SHIFT: each cycle compute sum bit from A[0], B[0], carry FF; shift A and B right; shift sum bit into accumulator MSB; update carry FF; increment counter.
REQ-019: SHIFT SHALL last exactly WIDTH cycles, then next state DONE.
REQ-020: On the SHIFT->DONE edge, result, cout, overflow, zero SHALL be written together; overflow = carry into MSB XOR carry out of MSB; zero = (final result == 0).
REQ-021: DONE SHALL last one cycle (done=1), then IDLE unless start=1, in which case a new operation loads as in REQ-016 and next state is SHIFT.
REQ-022: busy SHALL be 1 in SHIFT, 0 in IDLE and DONE.
REQ-023: Latency: start=1 in cycle 0 (state IDLE) -> done=1 in cycle WIDTH+1; back-to-back throughput one op per WIDTH+1 cycles.
REQ-024: start while busy=1 SHALL be ignored; a, b, sub changes during SHIFT SHALL NOT affect the operation.
REQ-025: result, cout, overflow, zero SHALL hold their last values until the next completion; they SHALL NOT change during SHIFT.
REQ-026: Arithmetic is modulo 2^WIDTH; carry out of MSB goes only to cout.
REQ-027: Sub of b=0: ~b+1 yields result=a, cout=1.

Reset
REQ-028: rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, result=0, cout=0, overflow=0, zero=0, carry FF=0, counter=0.
REQ-029: rst has priority over start and over any FSM transition.
REQ-030: rst during SHIFT SHALL abort the operation with no done pulse and outputs as in REQ-028.
REQ-031: rst released with start=1 in the same cycle: start is sampled on the first edge where rst=0.

Verification (WIDTH=8)
REQ-032: a=0x3C, b=0x05, sub=0, start pulse -> done in cycle 9, result=0x41, cout=0, overflow=0, zero=0.
REQ-033: a=0x7F, b=0x01, sub=0 -> result=0x80, cout=0, overflow=1, zero=0.
REQ-034: a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, overflow=0, zero=1.
REQ-035: a=0x05, b=0x07, sub=1 -> result=0xFE, cout=0, overflow=0; then a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, overflow=1.
REQ-036: start op (0x10+0x20), assert start with a=0xFF, b=0xFF in cycle 3 -> ignored, result=0x30; start held high in DONE cycle -> second op starts immediately, done again 9 cycles later.
REQ-037: start op, rst=1 in cycle 4 -> next cycle busy=0, all outputs 0, no done pulse; following op 0x01+0x01 -> result=0x02.
